// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the retiring value,
// commits it to a 32 x 32 register array, and serves two bypassed read ports.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] addp4out34,
   input  logic [DATA_W-1:0] alu_out34,
   input  logic [DATA_W-1:0] read_data234,
   input  logic [4:0]        write_reg34,
   input  logic              wr_en34,
   input  logic              memtoreg34,
   input  logic              jump34,
   input  logic              valid34,
   input  logic [4:0]        rs_addr,
   input  logic [4:0]        rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_we,
   output logic [31:0]       retired_count
);

   logic [DATA_W-1:0] r_regs [0:NREGS-1];
   logic [31:0]       r_retired_count;

   logic [DATA_W-1:0] w_wb_data;
   logic              w_wb_we;
   logic [NREGS-1:0]  w_wr_sel;

   // Link write outranks the load/ALU choice.
   always_comb begin
      if (jump34)
         w_wb_data = addp4out34;
      else if (memtoreg34)
         w_wb_data = read_data234;
      else
         w_wb_data = alu_out34;
   end

   assign w_wb_we = wr_en34 & valid34 & (write_reg34 != 5'd0);

   // One-hot write decode; entry 0 never selected so r0 stays zero.
   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_sel
         if (gi == 0) begin : g_r0
            assign w_wr_sel[gi] = 1'b0;
         end else begin : g_rn
            assign w_wr_sel[gi] = w_wb_we && (write_reg34 == 5'(gi));
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++)
            if (w_wr_sel[i])
               r_regs[i] <= w_wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_retired_count <= '0;
      else if (valid34)
         r_retired_count <= r_retired_count + 32'd1;
   end

   // Same-cycle write-through keeps decode from needing a WB forwarding path.
   always_comb begin
      if (rs_addr == 5'd0)
         rs_data = '0;
      else if (w_wb_we && (write_reg34 == rs_addr))
         rs_data = w_wb_data;
      else
         rs_data = r_regs[rs_addr];
   end

   always_comb begin
      if (rt_addr == 5'd0)
         rt_data = '0;
      else if (w_wb_we && (write_reg34 == rt_addr))
         rt_data = w_wb_data;
      else
         rt_data = r_regs[rt_addr];
   end

   assign wb_data       = w_wb_data;
   assign wb_we         = w_wb_we;
   assign retired_count = r_retired_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a reference model predicts port values per
// transaction, which are queued at drive time and compared once outputs settle.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addp4out34, alu_out34, read_data234;
   logic [4:0]  write_reg34;
   logic        wr_en34, memtoreg34, jump34, valid34;
   logic [4:0]  rs_addr, rt_addr;
   logic [31:0] rs_data, rt_data, wb_data;
   logic        wb_we;
   logic [31:0] retired_count;

   wb_regfile dut (
      .clk           (clk),
      .rst           (rst),
      .addp4out34    (addp4out34),
      .alu_out34     (alu_out34),
      .read_data234  (read_data234),
      .write_reg34   (write_reg34),
      .wr_en34       (wr_en34),
      .memtoreg34    (memtoreg34),
      .jump34        (jump34),
      .valid34       (valid34),
      .rs_addr       (rs_addr),
      .rt_addr       (rt_addr),
      .rs_data       (rs_data),
      .rt_data       (rt_data),
      .wb_data       (wb_data),
      .wb_we         (wb_we),
      .retired_count (retired_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] wbd;
      logic        we;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model_regs [0:31];
   logic [31:0] model_cnt;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_txn    = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                              input logic [4:0] wr, input logic [31:0] wbd);
      if (a == 5'd0)
         return 32'h0;
      else if (we && wr == a)
         return wbd;
      else
         return model_regs[a];
   endfunction

   // One pipeline cycle: drive at negedge, predict, compare after settle, then clock.
   task automatic step(input string tag, input logic r, input logic v, input logic we_in,
                       input logic m, input logic j, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                       input logic [4:0] ra, input logic [4:0] rb);
      exp_t e;
      logic [31:0] sel;
      logic        we_exp;
      rst = r; valid34 = v; wr_en34 = we_in; memtoreg34 = m; jump34 = j;
      write_reg34 = wr; alu_out34 = alu; read_data234 = ld; addp4out34 = pc4;
      rs_addr = ra; rt_addr = rb;
      sel    = j ? pc4 : (m ? ld : alu);
      we_exp = we_in & v & (wr != 5'd0);
      e.tag = tag;
      e.wbd = sel;
      e.we  = we_exp;
      e.rs  = model_read(ra, we_exp, wr, sel);
      e.rt  = model_read(rb, we_exp, wr, sel);
      e.cnt = model_cnt;
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      $display("txn %0d %s rs[%0d]=%h rt[%0d]=%h wb=%h we=%b cnt=%h",
               n_txn, e.tag, ra, rs_data, rb, rt_data, wb_data, wb_we, retired_count);
      n_txn++;
      check_val({e.tag, "_rs"},  rs_data, e.rs);
      check_val({e.tag, "_rt"},  rt_data, e.rt);
      check_val({e.tag, "_wbd"}, wb_data, e.wbd);
      check_val({e.tag, "_we"},  {31'd0, wb_we}, {31'd0, e.we});
      check_val({e.tag, "_cnt"}, retired_count, e.cnt);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
         model_cnt = 32'h0;
      end else begin
         if (we_exp) model_regs[wr] = sel;
         if (v) model_cnt = model_cnt + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic rd(input string tag, input logic [4:0] ra, input logic [4:0] rb);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, ra, rb);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
      model_cnt = 32'h0;
      rst = 1'b1; valid34 = 1'b0; wr_en34 = 1'b0; memtoreg34 = 1'b0; jump34 = 1'b0;
      write_reg34 = 5'd0; alu_out34 = 32'h0; read_data234 = 32'h0; addp4out34 = 32'h0;
      rs_addr = 5'd0; rt_addr = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      rd("post_rst", 5'd3, 5'd31);

      // Random preload, then a two-cycle reset must clear everything.
      for (int i = 1; i < 32; i++)
         step("preload", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'(i), $urandom, $urandom, $urandom,
              5'(i), 5'(32 - i));
      repeat (2)
         step("rst_hold", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'hABCD_0004, 32'h0, 32'h0,
              5'd4, 5'd6);
      for (int i = 0; i < 32; i++)
         rd("rst_sweep", 5'(i), 5'(31 - i));

      // Select priority into r5.
      step("sel_alu",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd0);
      rd("rd_alu", 5'd5, 5'd5);
      step("sel_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd1);
      rd("rd_load", 5'd5, 5'd5);
      step("sel_link", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd2);
      rd("rd_link", 5'd5, 5'd5);
      step("sel_link0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h44, 32'h55, 32'h66, 5'd2, 5'd5);
      rd("rd_link0", 5'd5, 5'd5);

      // Dual-port bypass, then array hold.
      step("bypass", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd7, 5'd7);
      rd("rd_r7", 5'd7, 5'd7);

      // Back-to-back writes to the same register.
      step("b2b_a", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'hAAAA_0001, 32'h0, 32'h0, 5'd8, 5'd1);
      step("b2b_b", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'hBBBB_0002, 32'h0, 32'h0, 5'd1, 5'd8);
      rd("rd_r8", 5'd8, 5'd0);

      // r0 write and bubble.
      step("r0_wr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0);
      rd("rd_r0", 5'd0, 5'd0);
      step("r9_set", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0909, 32'h0, 32'h0, 5'd9, 5'd2);
      step("bubble", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h9999_9999, 32'h0, 32'h0, 5'd9, 5'd9);
      rd("rd_r9", 5'd9, 5'd9);

      // Counter wrap from a forced near-max value.
      force dut.r_retired_count = 32'hFFFF_FFFE;
      #1;
      release dut.r_retired_count;
      model_cnt = 32'hFFFF_FFFE;
      @(negedge clk);
      step("wrap1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2);
      step("wrap2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4);
      rd("wrap_chk", 5'd5, 5'd7);

      // Reset collides with a write; the next edge commits normally.
      step("rst_coll", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h55, 32'h0, 32'h0, 5'd3, 5'd3);
      step("post_coll", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h55, 32'h0, 32'h0, 5'd2, 5'd3);
      rd("rd_r3", 5'd3, 5'd7);

      // Random traffic.
      for (int i = 0; i < 40; i++)
         step("rand", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
      for (int i = 0; i < 32; i += 2)
         rd("final", 5'(i), 5'(i + 1));

      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 5-stage pipeline. Consumes the MEM/WB pipeline register outputs (stage-3/4 fields), selects the writeback value (ALU result, load data, or PC+4 link), commits it to a 32 x 32-bit register file, and serves the two decode-stage read ports with same-cycle write-through bypass. Also maintains a retired-instruction counter for performance debug.

## Interface

Parameters:
- DATA_W, 32, register and datapath width
- NREGS, 32, register count; addresses are 5 bits; r0 hardwired to zero

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- addp4out34  in  32  PC+4 of the retiring instruction (link value)
- alu_out34  in  32  ALU result from MEM/WB
- read_data234  in  32  load data from MEM/WB
- write_reg34  in  5  destination register
- wr_en34  in  1  register write enable
- memtoreg34  in  1  1 = write load data, 0 = write ALU result
- jump34  in  1  1 = link write: write PC+4, overrides memtoreg34
- valid34  in  1  MEM/WB slot holds a real (non-bubble) instruction
- rs_addr  in  5  decode read port A address
- rt_addr  in  5  decode read port B address
- rs_data  out  32  read port A data (combinational)
- rt_data  out  32  read port B data (combinational)
- wb_data  out  32  selected writeback value (combinational, for forwarding)
- wb_we  out  1  effective write strobe = wr_en34 & valid34 & (write_reg34 != 0)
- retired_count  out  32  number of retired valid instructions

## Operation

- Writeback select: jump34 = 1 -> addp4out34; else memtoreg34 = 1 -> read_data234; else alu_out34. wb_data is driven from this select regardless of wr_en34.
- Commit: on rising clk with rst = 0 and wb_we = 1, regs[write_reg34] <= wb_data. Writes to r0 discarded; r0 always reads 0.
- Bubble: valid34 = 0 blocks the write and the counter, whatever wr_en34 is.
- Read ports: rs_data = 0 if rs_addr = 0; else wb_data if wb_we = 1 and write_reg34 = rs_addr (bypass); else regs[rs_addr]. rt_data identical with rt_addr. Both ports may hit the same address and both bypass.
- Counter: retired_count increments by 1 on each rising edge with rst = 0 and valid34 = 1 (independent of wr_en34). Wraps 0xFFFF_FFFF -> 0 with no flag.
- Reset: rst = 1 at a rising edge clears all 31 writable registers and retired_count to 0; any simultaneous write or count is dropped (reset dominates). wb_data and wb_we remain combinational functions of inputs during reset; rs_data/rt_data bypass remains active during reset.
- memwrite34, mem_read34, pcsrc34 are not consumed by this block.

## Timing

- Write latency: value visible in array one edge after the cycle wb_we = 1; visible on read ports in the same cycle via bypass (zero effective latency).
- Read ports, wb_data, wb_we: purely combinational, no clock latency.
- Counter: updates one edge after valid34 sampled high.
- Reset values: all regs 0, retired_count 0; rs_data/rt_data read 0 after reset unless bypassed.
- Back-to-back writes to the same register: last edge wins; intermediate value visible for exactly one cycle.
- Reset asserted mid-stream: the edge with rst = 1 discards the in-flight MEM/WB write; the first edge after rst deasserts commits normally.

## Test plan

- Reset: drive rst = 1 for 2 cycles after random preload -> all 32 registers read 0 on rs/rt, retired_count = 0.
- Select priority: write_reg34 = 5, alu_out34 = 0x11, read_data234 = 0x22, addp4out34 = 0x33; memtoreg34/jump34 = 00, 10, x1 -> r5 holds 0x11, 0x22, 0x33 respectively.
- Bypass: wr_en34 = 1, valid34 = 1, write_reg34 = 7, alu_out34 = 0xDEADBEEF, rs_addr = rt_addr = 7 same cycle -> rs_data = rt_data = 0xDEADBEEF before edge; array holds it after edge.
- r0 and bubble: write 0xFFFF_FFFF to r0 -> reads 0, wb_we = 0; write r9 with valid34 = 0 -> r9 unchanged, retired_count unchanged.
- Counter wrap: force 0xFFFF_FFFE, two valid cycles -> 0xFFFF_FFFF then 0x0000_0000.
- Reset collision: rst = 1 and write r3 = 0x55 on the same edge -> r3 = 0, count = 0; next edge with rst = 0 and same write -> r3 = 0x55, count = 1.
